tdm_demux_1to8: RTL and testbench

TDM_DEMUX_1TO8 -- requirements
Module: tdm_demux_1to8

---
 rtl/tdm_demux_1to8_if.sv | 30 +++
 rtl/tdm_demux_1to8.sv | 79 +++++++
 tb/tb_tdm_demux_1to8.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1to8_if.sv
// Bus bundle for the 1-to-8 TDM demultiplexer: serial word input side and
// the registered frame outputs.
interface tdm_demux_1to8_if #(
  parameter int W = 3
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_start;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [W-1:0] y4;
  logic [W-1:0] y5;
  logic [W-1:0] y6;
  logic [W-1:0] y7;
  logic [W-1:0] y8;
  logic [2:0]   slot;
  logic         frame_valid;
  logic         frame_err;

  modport master (
    output din, din_valid, frame_start,
    input  y1, y2, y3, y4, y5, y6, y7, y8, slot, frame_valid, frame_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output y1, y2, y3, y4, y5, y6, y7, y8, slot, frame_valid, frame_err
  );
endinterface

// File: rtl/tdm_demux_1to8.sv
// Collects eight time-multiplexed words into a shadow frame and publishes
// them on y1..y8 only when the frame completes; frame_start mid-frame resyncs.
//
// state  | meaning
// IDLE   | waiting for a valid word with frame_start (slot 0)
// RECV   | collecting slots 1..7
module tdm_demux_1to8 #(
  parameter int W = 3
) (
  input  logic               clk,
  input  logic               reset,
  tdm_demux_1to8_if.slave    bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]   r_state;
  logic [2:0]   r_slot;
  logic [W-1:0] r_shadow [0:6];
  logic [W-1:0] r_y      [0:7];
  logic         r_frame_valid;
  logic         r_frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_slot        <= 3'd0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      for (int i = 0; i < 7; i++) r_shadow[i] <= '0;
      for (int i = 0; i < 8; i++) r_y[i] <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (bus.din_valid) begin
        case (r_state)
          S_IDLE: begin
            if (bus.frame_start) begin
              r_shadow[0] <= bus.din;
              r_slot      <= 3'd1;
              r_state     <= S_RECV;
            end
          end
          default: begin
            // A new frame_start always wins, even on the slot-7 word.
            if (bus.frame_start) begin
              r_frame_err <= 1'b1;
              r_shadow[0] <= bus.din;
              r_slot      <= 3'd1;
            end else if (r_slot == 3'd7) begin
              for (int i = 0; i < 7; i++) r_y[i] <= r_shadow[i];
              r_y[7]        <= bus.din;
              r_frame_valid <= 1'b1;
              r_slot        <= 3'd0;
              r_state       <= S_IDLE;
            end else begin
              r_shadow[r_slot] <= bus.din;
              r_slot           <= r_slot + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.y1          = r_y[0];
  assign bus.y2          = r_y[1];
  assign bus.y3          = r_y[2];
  assign bus.y4          = r_y[3];
  assign bus.y5          = r_y[4];
  assign bus.y6          = r_y[5];
  assign bus.y7          = r_y[6];
  assign bus.y8          = r_y[7];
  assign bus.slot        = r_slot;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed bench for tdm_demux_1to8: hand-computed frames, gaps, resync,
// idle discard, async reset and back-to-back frames.
module tb_tdm_demux_1to8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  tdm_demux_1to8_if #(.W(3)) bus ();

  tdm_demux_1to8 #(.W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic logic [31:0] y_all();
    return {8'd0, bus.y8, bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1};
  endfunction

  // Drive one cycle of input, then sample just after the edge that took it.
  task automatic put(input logic v, input logic fs, input int d);
    bus.din_valid   = v;
    bus.frame_start = fs;
    bus.din         = 3'(d);
    @(posedge clk);
    #1;
  endtask

  // Full frame starting at slot 0; w holds slot 0 in bits [2:0].
  task automatic frame(input string tag, input logic [23:0] w);
    for (int i = 0; i < 8; i++) begin
      put(1'b1, i == 0, int'(w[3*i +: 3]));
      chk({tag, "_err"}, 32'(bus.frame_err), 32'd0);
      if (i < 7) begin
        chk({tag, "_vld_lo"}, 32'(bus.frame_valid), 32'd0);
        chk({tag, "_slot"}, 32'(bus.slot), 32'(i + 1));
      end else begin
        chk({tag, "_vld_hi"}, 32'(bus.frame_valid), 32'd1);
        chk({tag, "_slot0"}, 32'(bus.slot), 32'd0);
        chk({tag, "_y"}, y_all(), 32'(w));
      end
    end
  endtask

  logic [23:0] exp_y;

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.frame_start = 1'b0;
    #7;
    chk("rst_slot", 32'(bus.slot), 32'd0);
    chk("rst_y", y_all(), 32'd0);
    chk("rst_vld", 32'(bus.frame_valid), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    #5 reset = 1'b0;

    // Basic frame
    exp_y = pk(1, 2, 3, 4, 5, 6, 7, 0);
    frame("frm", exp_y);
    put(1'b0, 1'b0, 0);
    chk("frm_pulse_one", 32'(bus.frame_valid), 32'd0);
    chk("frm_y_hold", y_all(), 32'(exp_y));

    // Gap of 3 after slot 3; frame_start without din_valid must be ignored
    for (int i = 0; i < 4; i++) put(1'b1, i == 0, i + 1);
    for (int g = 0; g < 3; g++) begin
      put(1'b0, 1'b1, 6);
      chk("gap_slot", 32'(bus.slot), 32'd4);
      chk("gap_vld", 32'(bus.frame_valid), 32'd0);
      chk("gap_err", 32'(bus.frame_err), 32'd0);
    end
    for (int i = 4; i < 8; i++) begin
      put(1'b1, 1'b0, (i + 1) % 8);
      chk("gap_vld_t", 32'(bus.frame_valid), 32'(i == 7));
    end
    chk("gap_y", y_all(), 32'(exp_y));

    // Resync: 5 words, frame_start with 6, 7 more words
    for (int i = 0; i < 5; i++) put(1'b1, i == 0, i + 1);
    put(1'b1, 1'b1, 6);
    chk("rsy_err", 32'(bus.frame_err), 32'd1);
    chk("rsy_vld", 32'(bus.frame_valid), 32'd0);
    chk("rsy_slot", 32'(bus.slot), 32'd1);
    chk("rsy_y_hold", y_all(), 32'(exp_y));
    put(1'b1, 1'b0, 7);
    chk("rsy_err_one", 32'(bus.frame_err), 32'd0);
    for (int i = 0; i < 6; i++) put(1'b1, 1'b0, i);
    chk("rsy_vld", 32'(bus.frame_valid), 32'd1);
    exp_y = pk(6, 7, 0, 1, 2, 3, 4, 5);
    chk("rsy_y", y_all(), 32'(exp_y));

    // Idle discard
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 1'b0, i + 3);
      chk("idl_slot", 32'(bus.slot), 32'd0);
      chk("idl_vld", 32'(bus.frame_valid), 32'd0);
      chk("idl_err", 32'(bus.frame_err), 32'd0);
    end
    chk("idl_y_hold", y_all(), 32'(exp_y));
    exp_y = pk(2, 3, 4, 5, 6, 7, 0, 1);
    frame("idl_frm", exp_y);

    // frame_start on the slot-7 word is a resync, not a completion
    for (int i = 0; i < 7; i++) put(1'b1, i == 0, 4);
    put(1'b1, 1'b1, 7);
    chk("s7_err", 32'(bus.frame_err), 32'd1);
    chk("s7_vld", 32'(bus.frame_valid), 32'd0);
    chk("s7_slot", 32'(bus.slot), 32'd1);
    chk("s7_y_hold", y_all(), 32'(exp_y));
    for (int i = 0; i < 7; i++) put(1'b1, 1'b0, i);
    chk("s7_vld_done", 32'(bus.frame_valid), 32'd1);
    exp_y = pk(7, 0, 1, 2, 3, 4, 5, 6);
    chk("s7_y", y_all(), 32'(exp_y));

    // Async reset mid-frame at slot 4
    for (int i = 0; i < 4; i++) put(1'b1, i == 0, i + 1);
    chk("ar_pre_slot", 32'(bus.slot), 32'd4);
    put(1'b0, 1'b0, 0);
    #3 reset = 1'b1;
    #1;
    chk("ar_slot", 32'(bus.slot), 32'd0);
    chk("ar_y", y_all(), 32'd0);
    chk("ar_vld", 32'(bus.frame_valid), 32'd0);
    chk("ar_err", 32'(bus.frame_err), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    put(1'b1, 1'b0, 5);
    chk("ar_need_fs", 32'(bus.slot), 32'd0);
    exp_y = pk(3, 4, 5, 6, 7, 0, 1, 2);
    frame("ar_frm", exp_y);

    // Back-to-back frames, pulses 8 cycles apart
    exp_y = pk(1, 2, 3, 4, 5, 6, 7, 0);
    frame("b2b_a", exp_y);
    exp_y = pk(5, 6, 7, 0, 1, 2, 3, 4);
    frame("b2b_b", exp_y);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
